// File: rtl/vga_fetch_sched_pkg.sv
// rtl/vga_fetch_sched_pkg.sv - shared timing constants, FSM encoding and target-line helper
package vga_fetch_sched_pkg;

  localparam int M0_V_VIEW_DEF = 480;
  localparam int M0_V_MAX_DEF  = 524;
  localparam int M1_V_VIEW_DEF = 900;
  localparam int M1_V_MAX_DEF  = 931;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STREAM = 2'd2
  } fetch_state_e;

  // Line two ahead of the beam, wrapped into 0..v_max.
  function automatic logic [10:0] target_line(input logic [9:0] v, input logic [10:0] v_max);
    logic [10:0] t2;
    t2 = {1'b0, v} + 11'd2;
    if (t2 > v_max) t2 = t2 - v_max - 11'd1;
    return t2;
  endfunction

endpackage

// File: rtl/vga_fetch_sched.sv
// rtl/vga_fetch_sched.sv - per-scanline ROM prefetch scheduler with ping-pong line buffer
module vga_fetch_sched
  import vga_fetch_sched_pkg::*;
#(
  parameter int BURST_BYTES = 80,
  parameter int STRIDE      = 80,
  parameter int M0_V_VIEW   = M0_V_VIEW_DEF,
  parameter int M0_V_MAX    = M0_V_MAX_DEF,
  parameter int M1_V_VIEW   = M1_V_VIEW_DEF,
  parameter int M1_V_MAX    = M1_V_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_enable,
  input  logic        mode_req,
  input  logic [23:0] base_addr,
  input  logic [9:0]  vpos,
  input  logic        hmax,
  input  logic        vmax,
  output logic        o_mode,
  output logic        o_req,
  output logic [23:0] o_addr,
  output logic [7:0]  o_len,
  input  logic        i_ack,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_buf_we,
  output logic [7:0]  o_buf_waddr,
  output logic [7:0]  o_buf_wdata,
  output logic        o_disp_bank,
  output logic        o_line_done,
  output logic        o_underrun,
  output logic [7:0]  o_underrun_cnt
);

  localparam logic [10:0] M0_VIEW  = 11'(M0_V_VIEW);
  localparam logic [10:0] M0_MAX   = 11'(M0_V_MAX);
  localparam logic [10:0] M1_VIEW  = 11'(M1_V_VIEW);
  localparam logic [10:0] M1_MAX   = 11'(M1_V_MAX);
  localparam logic [7:0]  LAST_IDX = 8'(BURST_BYTES - 1);
  localparam logic [23:0] STRIDE_W = 24'(STRIDE);

  fetch_state_e state, state_nx;
  logic [7:0]   byte_cnt;
  logic         fill_bank;
  logic [23:0]  next_addr;
  logic [10:0]  v_view, v_max, tgt;
  logic         fetch_ok, fetch_start, overrun, beat, last_beat;

  assign o_len = 8'(BURST_BYTES);

  // Target line is computed with the mode in force before any frame-boundary switch.
  always_comb begin
    v_view   = o_mode ? M1_VIEW : M0_VIEW;
    v_max    = o_mode ? M1_MAX : M0_MAX;
    tgt      = target_line(vpos, v_max);
    fetch_ok = hmax && i_enable && (tgt < v_view);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (fetch_ok)  state_nx = ST_REQ;
      ST_REQ:    if (i_ack)     state_nx = ST_STREAM;
      ST_STREAM: if (last_beat) state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req       = (state == ST_REQ);
    fetch_start = fetch_ok && (state == ST_IDLE);
    overrun     = fetch_ok && (state != ST_IDLE);
    beat        = (state == ST_STREAM) && i_valid;
    last_beat   = beat && (byte_cnt == LAST_IDX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_disp_bank <= 1'b0;
      o_mode      <= 1'b0;
      fill_bank   <= 1'b0;
      o_addr      <= '0;
      next_addr   <= '0;
    end else begin
      if (hmax) o_disp_bank <= ~o_disp_bank;
      if (hmax && vmax) o_mode <= mode_req;
      if (fetch_start) begin
        // Post-toggle complement of the display bank equals its pre-toggle value.
        fill_bank <= o_disp_bank;
        if (tgt == 11'd0) begin
          o_addr    <= base_addr;
          next_addr <= base_addr + STRIDE_W;
        end else begin
          o_addr    <= next_addr;
          next_addr <= next_addr + STRIDE_W;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt    <= '0;
      o_buf_we    <= 1'b0;
      o_buf_waddr <= '0;
      o_buf_wdata <= '0;
      o_line_done <= 1'b0;
    end else begin
      o_buf_we    <= beat;
      o_line_done <= last_beat;
      if (state == ST_REQ && i_ack) byte_cnt <= '0;
      if (beat) begin
        o_buf_waddr <= {fill_bank, byte_cnt[6:0]};
        o_buf_wdata <= i_data;
        byte_cnt    <= byte_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_underrun     <= 1'b0;
      o_underrun_cnt <= '0;
    end else if (overrun) begin
      o_underrun <= 1'b1;
      if (o_underrun_cnt != 8'hFF) o_underrun_cnt <= o_underrun_cnt + 8'd1;
    end
  end

endmodule
